// File: rtl/con_pkg.sv
// Shared types and constants for the con-port loader: FSM state, debug view,
// and the default data-memory geometry of the core's con port.
package con_pkg;

  localparam int CON_DATAMEM_BITS = 10;
  localparam int CON_WORD_WIDTH   = 32;

  localparam logic [3:0] CON_WE_FULL = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_LO,
    ST_CNT_HI,
    ST_DATA,
    ST_WRITE,
    ST_DONE
  } con_state_e;

  typedef struct packed {
    con_state_e state;
    logic [1:0] byte_idx;
  } con_dbg_t;

  function automatic logic con_state_ready(con_state_e s);
    return (s == ST_CNT_LO) || (s == ST_CNT_HI) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/con_loader_if.sv
// Byte-stream input and con-port write bundle of the loader.
// Handshake: a byte moves on a posedge where in_valid && in_ready; in_data is held while in_valid waits.
interface con_loader_if
  import con_pkg::*;
#(
  parameter int DATAMEM_BITS = CON_DATAMEM_BITS,
  parameter int WORD_WIDTH   = CON_WORD_WIDTH
) ();

  logic [7:0]              in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [3:0]              con_write;
  logic [DATAMEM_BITS-1:0] con_addr;
  logic [WORD_WIDTH-1:0]   con_in;

  modport master (
    output in_data, in_valid,
    input  in_ready, con_write, con_addr, con_in
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, con_write, con_addr, con_in
  );

endinterface

// File: rtl/con_word_packer.sv
// Collects four stream bytes into one 32-bit word; word_o already includes
// the byte being accepted so the full word is available on the 4th accept.
module con_word_packer #(
  parameter bit BYTE_SWAP = 1'b1
) (
  input  logic        CLK,
  input  logic        nrst,
  input  logic        clr_i,
  input  logic        accept_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_full_o,
  output logic [1:0]  byte_idx_o
);

  logic [23:0] sr_q;
  logic [23:0] sr_d;
  logic [1:0]  idx_q;

  // BYTE_SWAP=1 shifts left (first byte ends in [31:24]); 0 shifts right.
  assign word_o      = BYTE_SWAP ? {sr_q, byte_i} : {byte_i, sr_q};
  assign sr_d        = BYTE_SWAP ? word_o[23:0] : word_o[31:8];
  assign word_full_o = accept_i && (idx_q == 2'd3);
  assign byte_idx_o  = idx_q;

  always_ff @(posedge CLK) begin
    if (!nrst || clr_i) begin
      sr_q  <= '0;
      idx_q <= '0;
    end else if (accept_i) begin
      sr_q  <= sr_d;
      idx_q <= idx_q + 2'd1;
    end
  end

endmodule

// File: rtl/con_loader.sv
// Loads a counted frame of 32-bit words from a byte stream into data memory
// through the core's con port, holding the core in reset until the frame ends.
module con_loader
  import con_pkg::*;
#(
  parameter int DATAMEM_BITS = CON_DATAMEM_BITS,
  parameter int WORD_WIDTH   = CON_WORD_WIDTH,
  parameter bit BYTE_SWAP    = 1'b1
) (
  input  logic            CLK,
  input  logic            nrst,
  input  logic            start,
  con_loader_if.slave     bus,
  output logic            core_nrst,
  output logic            load_done,
  output logic            ovf,
  output con_dbg_t        dbg
);

  con_state_e              state_q;
  logic [7:0]              cnt_lo_q;
  logic [15:0]             remaining_q;
  logic [DATAMEM_BITS:0]   addr_q;
  logic [3:0]              con_write_q;
  logic [DATAMEM_BITS-1:0] con_addr_q;
  logic [WORD_WIDTH-1:0]   con_in_q;
  logic                    core_nrst_q;
  logic                    load_done_q;
  logic                    ovf_q;

  logic        in_ready;
  logic        accept;
  logic        start_ok;
  logic        addr_in_range;
  logic [31:0] word;
  logic        word_full;
  logic [1:0]  byte_idx;

  assign in_ready      = con_state_ready(state_q);
  assign accept        = bus.in_valid && in_ready;
  assign start_ok      = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign addr_in_range = !addr_q[DATAMEM_BITS];

  con_word_packer #(
    .BYTE_SWAP (BYTE_SWAP)
  ) u_packer (
    .CLK         (CLK),
    .nrst        (nrst),
    .clr_i       (start_ok),
    .accept_i    (accept && (state_q == ST_DATA)),
    .byte_i      (bus.in_data),
    .word_o      (word),
    .word_full_o (word_full),
    .byte_idx_o  (byte_idx)
  );

  always_ff @(posedge CLK) begin
    if (!nrst) begin
      state_q     <= ST_IDLE;
      cnt_lo_q    <= '0;
      remaining_q <= '0;
      addr_q      <= '0;
      con_write_q <= '0;
      con_addr_q  <= '0;
      con_in_q    <= '0;
      core_nrst_q <= 1'b0;
      load_done_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      con_write_q <= '0;
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q     <= ST_CNT_LO;
            addr_q      <= '0;
            ovf_q       <= 1'b0;
            core_nrst_q <= 1'b0;
            load_done_q <= 1'b0;
          end
        end
        ST_CNT_LO: begin
          if (accept) begin
            cnt_lo_q <= bus.in_data;
            state_q  <= ST_CNT_HI;
          end
        end
        ST_CNT_HI: begin
          if (accept) begin
            remaining_q <= {bus.in_data, cnt_lo_q};
            if ({bus.in_data, cnt_lo_q} == 16'd0) begin
              state_q     <= ST_DONE;
              core_nrst_q <= 1'b1;
              load_done_q <= 1'b1;
            end else begin
              state_q <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          // Strobe and data are loaded here so they are visible during WRITE.
          if (word_full) begin
            state_q <= ST_WRITE;
            if (addr_in_range) begin
              con_write_q <= CON_WE_FULL;
              con_addr_q  <= addr_q[DATAMEM_BITS-1:0];
              con_in_q    <= word;
            end else begin
              ovf_q <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          remaining_q <= remaining_q - 16'd1;
          // addr saturates at depth so a long frame cannot wrap back into memory.
          if (addr_in_range) addr_q <= addr_q + 1'b1;
          if (remaining_q == 16'd1) begin
            state_q     <= ST_DONE;
            core_nrst_q <= 1'b1;
            load_done_q <= 1'b1;
          end else begin
            state_q <= ST_DATA;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.con_write = con_write_q;
  assign bus.con_addr  = con_addr_q;
  assign bus.con_in    = con_in_q;
  assign core_nrst     = core_nrst_q;
  assign load_done     = load_done_q;
  assign ovf           = ovf_q;
  assign dbg.state     = state_q;
  assign dbg.byte_idx  = byte_idx;

endmodule

// File: tb/tb_con_loader.sv
// Bench for con_loader: three instances (big-endian, little-endian, 4-word
// memory) share one byte stream; writes are scored against a frame model.
module tb_con_loader;
  import con_pkg::*;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       nrst     = 1'b0;
  logic       start    = 1'b0;
  logic [7:0] in_data  = 8'h00;
  logic       in_valid = 1'b0;

  logic core_nrst_a, core_nrst_b, core_nrst_c;
  logic load_done_a, load_done_b, load_done_c;
  logic ovf_a, ovf_b, ovf_c;
  con_dbg_t dbg_a, dbg_b, dbg_c;

  con_loader_if #(.DATAMEM_BITS(10), .WORD_WIDTH(32)) if_a ();
  con_loader_if #(.DATAMEM_BITS(10), .WORD_WIDTH(32)) if_b ();
  con_loader_if #(.DATAMEM_BITS(2),  .WORD_WIDTH(32)) if_c ();

  assign if_a.in_data = in_data;  assign if_a.in_valid = in_valid;
  assign if_b.in_data = in_data;  assign if_b.in_valid = in_valid;
  assign if_c.in_data = in_data;  assign if_c.in_valid = in_valid;

  con_loader #(.DATAMEM_BITS(10), .WORD_WIDTH(32), .BYTE_SWAP(1'b1)) dut_a (
    .CLK(CLK), .nrst(nrst), .start(start), .bus(if_a.slave),
    .core_nrst(core_nrst_a), .load_done(load_done_a), .ovf(ovf_a), .dbg(dbg_a));
  con_loader #(.DATAMEM_BITS(10), .WORD_WIDTH(32), .BYTE_SWAP(1'b0)) dut_b (
    .CLK(CLK), .nrst(nrst), .start(start), .bus(if_b.slave),
    .core_nrst(core_nrst_b), .load_done(load_done_b), .ovf(ovf_b), .dbg(dbg_b));
  con_loader #(.DATAMEM_BITS(2), .WORD_WIDTH(32), .BYTE_SWAP(1'b1)) dut_c (
    .CLK(CLK), .nrst(nrst), .start(start), .bus(if_c.slave),
    .core_nrst(core_nrst_c), .load_done(load_done_c), .ovf(ovf_c), .dbg(dbg_c));

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [41:0] exp_q[3][$];   // {addr[9:0], data[31:0]} per instance
  logic        prev_we[3] = '{1'b0, 1'b0, 1'b0};
  logic [7:0]  frame_q[$];

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
  endtask

  task automatic see_write(int d, logic [3:0] we, logic [41:0] got);
    if (we != 4'h0) begin
      chk($sformatf("strobe_value_%0d", d), 64'(we), 64'hF);
      chk($sformatf("strobe_width_%0d", d), 64'(prev_we[d]), 64'd0);
      if (exp_q[d].size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write_%0d: got 0x%0h, required no write", d, got);
      end else begin
        chk($sformatf("write_%0d", d), 64'(got), 64'(exp_q[d].pop_front()));
      end
    end
    prev_we[d] = (we != 4'h0);
  endtask

  always @(negedge CLK) begin
    see_write(0, if_a.con_write, {if_a.con_addr, if_a.con_in});
    see_write(1, if_b.con_write, {if_b.con_addr, if_b.con_in});
    see_write(2, if_c.con_write, {8'd0, if_c.con_addr, if_c.con_in});
  end

  // Reference model: the frame in frame_q mapped to (address, word) writes.
  task automatic model_frame();
    int cnt;
    cnt = int'(frame_q[1]) * 256 + int'(frame_q[0]);
    for (int k = 0; k < cnt; k++) begin
      int unsigned b0, b1, b2, b3;
      logic [31:0] w_be, w_le;
      b0 = frame_q[2 + 4*k];     b1 = frame_q[3 + 4*k];
      b2 = frame_q[4 + 4*k];     b3 = frame_q[5 + 4*k];
      w_be = 32'(b0 * 16777216 + b1 * 65536 + b2 * 256 + b3);
      w_le = 32'(b3 * 16777216 + b2 * 65536 + b1 * 256 + b0);
      if (k < 1024) begin
        exp_q[0].push_back({10'(k), w_be});
        exp_q[1].push_back({10'(k), w_le});
      end
      if (k < 4) exp_q[2].push_back({10'(k), w_be});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    chk("ready_after_start", 64'(if_a.in_ready), 64'd1);
    chk("core_held_after_start", 64'(core_nrst_a), 64'd0);
    chk("done_clear_after_start", 64'(load_done_a), 64'd0);
    chk("ovf_clear_after_start", 64'(ovf_c), 64'd0);
  endtask

  task automatic send_byte(logic [7:0] b, int gap, int pos);
    int t;
    in_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(negedge CLK);
      if (pos >= 2) chk("idx_hold_in_stall", 64'(dbg_a.byte_idx), 64'((pos - 2) % 4));
    end
    in_data  = b;
    in_valid = 1'b1;
    t = 0;
    while (!if_a.in_ready && t < 64) begin
      @(negedge CLK);
      t++;
    end
    if (t == 64) begin
      n_checks++;
      $display("FAIL ready_timeout: byte %0d not accepted within 64 cycles, required acceptance", pos);
    end
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  task automatic run_frame(int max_gap);
    logic [15:0] cnt;
    cnt = {frame_q[1], frame_q[0]};
    pulse_start();
    for (int i = 0; i < frame_q.size(); i++)
      send_byte(frame_q[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0, i);
    if (cnt == 16'd0) begin
      chk("zero_release", 64'(core_nrst_a), 64'd1);
      chk("zero_load_done", 64'(load_done_a), 64'd1);
      chk("zero_no_strobe", 64'(if_a.con_write), 64'd0);
    end else begin
      chk("write_after_last_accept", 64'(if_a.con_write), 64'hF);
      chk("core_held_in_write", 64'(core_nrst_a), 64'd0);
      @(negedge CLK);
      chk("release_after_write", 64'(core_nrst_a), 64'd1);
      chk("load_done", 64'(load_done_a), 64'd1);
    end
    repeat (3) @(negedge CLK);
    for (int d = 0; d < 3; d++) chk($sformatf("pending_writes_%0d", d), 64'(exp_q[d].size()), 64'd0);
    chk("ovf_a", 64'(ovf_a), 64'd0);
    chk("ovf_c", 64'(ovf_c), 64'(cnt > 16'd4));
    chk("state_done", 64'(dbg_a.state), 64'(ST_DONE));
    chk("ready_low_in_done", 64'(if_a.in_ready), 64'd0);
  endtask

  task automatic check_reset_values();
    chk("rst_in_ready", 64'(if_a.in_ready), 64'd0);
    chk("rst_con_write", 64'(if_a.con_write), 64'd0);
    chk("rst_con_addr", 64'(if_a.con_addr), 64'd0);
    chk("rst_con_in", 64'(if_a.con_in), 64'd0);
    chk("rst_core_nrst", 64'(core_nrst_a), 64'd0);
    chk("rst_load_done", 64'(load_done_a), 64'd0);
    chk("rst_ovf", 64'(ovf_c), 64'd0);
    chk("rst_state", 64'(dbg_a.state), 64'(ST_IDLE));
    chk("rst_byte_idx", 64'(dbg_a.byte_idx), 64'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] stream;   // bytes in arrival order, first byte in [31:24]
    logic [31:0] exp_be;
    logic [31:0] exp_le;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h11223344, 32'h11223344, 32'h44332211};
    vecs[1] = '{32'hDEADBEEF, 32'hDEADBEEF, 32'hEFBEADDE};
    vecs[2] = '{32'h000000FF, 32'h000000FF, 32'hFF000000};
    vecs[3] = '{32'h80010203, 32'h80010203, 32'h03020180};

    repeat (3) @(negedge CLK);
    check_reset_values();
    nrst = 1'b1;
    @(negedge CLK);
    chk("idle_state", 64'(dbg_a.state), 64'(ST_IDLE));

    // start and in_valid together in IDLE: no byte taken
    start = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    @(negedge CLK);
    start = 1'b0; in_valid = 1'b0;
    chk("start_with_valid_state", 64'(dbg_a.state), 64'(ST_CNT_LO));

    // basic two-word load; the start inside run_frame lands mid-frame and is ignored
    frame_q = '{8'h02, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
    exp_q[0].push_back({10'd0, 32'hDEADBEEF}); exp_q[0].push_back({10'd1, 32'h01020304});
    exp_q[1].push_back({10'd0, 32'hEFBEADDE}); exp_q[1].push_back({10'd1, 32'h04030201});
    exp_q[2].push_back({10'd0, 32'hDEADBEEF}); exp_q[2].push_back({10'd1, 32'h01020304});
    run_frame(0);

    // zero count
    frame_q = '{8'h00, 8'h00};
    run_frame(0);

    // table: single-word frames, increasing stall allowance
    for (int i = 0; i < 4; i++) begin
      logic [31:0] s;
      s = vecs[i].stream;
      frame_q = '{8'h01, 8'h00, s[31:24], s[23:16], s[15:8], s[7:0]};
      exp_q[0].push_back({10'd0, vecs[i].exp_be});
      exp_q[1].push_back({10'd0, vecs[i].exp_le});
      exp_q[2].push_back({10'd0, vecs[i].exp_be});
      run_frame(i);
    end

    // overflow on the 4-word instance: count 6, stalls up to 2
    frame_q = '{8'h06, 8'h00};
    for (int i = 0; i < 24; i++) frame_q.push_back(8'($urandom_range(0, 255)));
    model_frame();
    run_frame(2);

    // randomized frames with stalls of 0..5 cycles
    for (int f = 0; f < 6; f++) begin
      int cnt;
      cnt = int'($urandom_range(1, 7));
      frame_q = '{8'(cnt), 8'h00};
      for (int i = 0; i < 4 * cnt; i++) frame_q.push_back(8'($urandom_range(0, 255)));
      model_frame();
      run_frame(5);
    end

    // abort after two data bytes, with an ignored start mid-word first
    pulse_start();
    send_byte(8'h01, 0, 0); send_byte(8'h00, 0, 1);
    send_byte(8'hDE, 0, 2); send_byte(8'hAD, 0, 3);
    chk("partial_idx", 64'(dbg_a.byte_idx), 64'd2);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    chk("midframe_start_state", 64'(dbg_a.state), 64'(ST_DATA));
    chk("midframe_start_idx", 64'(dbg_a.byte_idx), 64'd2);
    nrst = 1'b0;
    @(negedge CLK);
    check_reset_values();
    nrst = 1'b1;
    @(negedge CLK);
    chk("after_abort_state", 64'(dbg_a.state), 64'(ST_IDLE));

    frame_q = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    exp_q[0].push_back({10'd0, 32'h11223344});
    exp_q[1].push_back({10'd0, 32'h44332211});
    exp_q[2].push_back({10'd0, 32'h11223344});
    run_frame(0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
